// File: rtl/rvx_gpio_arbiter_pkg.sv
// ============================================================================
// Module  : rvx_gpio_arbiter_pkg
// Brief   : Shared types and constants for the two-master rvx_gpio arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rvx_gpio_arbiter_pkg;

  localparam int unsigned c_addr_w = 5;
  localparam int unsigned c_data_w = 32;
  localparam int unsigned c_strb_w = 4;

  // rvx_gpio register map
  localparam logic [4:0] c_gpio_output_enable_reg = 5'h00;
  localparam logic [4:0] c_gpio_output_reg        = 5'h04;
  localparam logic [4:0] c_gpio_input_reg         = 5'h08;

  typedef enum logic [1:0] {
    RVX_GPIO_ARB_IDLE  = 2'd0,
    RVX_GPIO_ARB_ISSUE = 2'd1,
    RVX_GPIO_ARB_WAIT  = 2'd2
  } arb_state_e;

  // Round-robin pick: on a tie the master that was not granted last wins.
  function automatic logic arb_pick(input logic full0, input logic full1,
                                    input logic last_grant);
    return (full0 & full1) ? ~last_grant : full1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvx_gpio_arbiter_slot.sv
// ============================================================================
// Module  : rvx_gpio_arbiter_slot
// Brief   : One-entry request buffer per master with sticky protocol error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvx_gpio_arbiter_slot
  import rvx_gpio_arbiter_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [c_addr_w-1:0] i_rw_address,
  input  logic [c_data_w-1:0] i_write_data,
  input  logic [c_strb_w-1:0] i_write_strobe,
  input  logic                i_read_request,
  input  logic                i_write_request,
  input  logic                i_in_flight,
  input  logic                i_grant,
  output logic                o_full,
  output logic                o_rd,
  output logic                o_wr,
  output logic [c_addr_w-1:0] o_rw_address,
  output logic [c_data_w-1:0] o_write_data,
  output logic [c_strb_w-1:0] o_write_strobe,
  output logic                o_protocol_error
);

  logic                r_full;
  logic                r_rd;
  logic                r_wr;
  logic [c_addr_w-1:0] r_addr;
  logic [c_data_w-1:0] r_wdata;
  logic [c_strb_w-1:0] r_strobe;
  logic                r_err;

  logic w_any_req;
  logic w_capture;
  logic w_violation;

  assign w_any_req   = i_read_request | i_write_request;
  assign w_capture   = w_any_req & ~r_full & ~i_in_flight;
  assign w_violation = w_any_req & (r_full | i_in_flight);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strobe <= '0;
      r_err    <= 1'b0;
    end else begin
      // A grant only happens on a full slot, so it never races a capture.
      if (i_grant) begin
        r_full <= 1'b0;
      end else if (w_capture) begin
        r_full   <= 1'b1;
        r_rd     <= i_read_request;
        r_wr     <= i_write_request;
        r_addr   <= i_rw_address;
        r_wdata  <= i_write_data;
        r_strobe <= i_write_strobe;
      end
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_full           = r_full;
  assign o_rd             = r_rd;
  assign o_wr             = r_wr;
  assign o_rw_address     = r_addr;
  assign o_write_data     = r_wdata;
  assign o_write_strobe   = r_strobe;
  assign o_protocol_error = r_err;

endmodule

`default_nettype wire

// File: rtl/rvx_gpio_arbiter.sv
// ============================================================================
// Module  : rvx_gpio_arbiter
// Brief   : Round-robin arbiter sharing one rvx_gpio register port between
//           two masters, one outstanding transaction at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvx_gpio_arbiter
  import rvx_gpio_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  m0_rw_address,
  output logic [31:0] m0_read_data,
  input  logic        m0_read_request,
  output logic        m0_read_response,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  input  logic        m0_write_request,
  output logic        m0_write_response,
  input  logic [4:0]  m1_rw_address,
  output logic [31:0] m1_read_data,
  input  logic        m1_read_request,
  output logic        m1_read_response,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  input  logic        m1_write_request,
  output logic        m1_write_response,
  output logic [4:0]  s_rw_address,
  input  logic [31:0] s_read_data,
  output logic        s_read_request,
  input  logic        s_read_response,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_write_strobe,
  output logic        s_write_request,
  input  logic        s_write_response,
  output logic [1:0]  protocol_error
);

  arb_state_e  r_state;
  logic        r_owner;
  logic        r_last_grant;
  logic [4:0]  r_s_addr;
  logic [31:0] r_s_wdata;
  logic [3:0]  r_s_strobe;
  logic        r_s_rd_req;
  logic        r_s_wr_req;

  logic [1:0]  w_full;
  logic [1:0]  w_rd;
  logic [1:0]  w_wr;
  logic [4:0]  w_addr   [2];
  logic [31:0] w_wdata  [2];
  logic [3:0]  w_strobe [2];
  logic [1:0]  w_in_flight;
  logic [1:0]  w_grant;
  logic        w_grant_valid;
  logic        w_grant_idx;
  logic        w_s_resp;
  logic        w_wait;

  assign w_s_resp      = s_read_response | s_write_response;
  assign w_wait        = (r_state == RVX_GPIO_ARB_WAIT);
  assign w_grant_valid = (r_state == RVX_GPIO_ARB_IDLE) & (|w_full);
  assign w_grant_idx   = arb_pick(w_full[0], w_full[1], r_last_grant);
  assign w_grant[0]    = w_grant_valid & ~w_grant_idx;
  assign w_grant[1]    = w_grant_valid &  w_grant_idx;

  // The owner frees its slot for reuse in the very cycle its response returns.
  assign w_in_flight[0] = ~r_owner & ((r_state == RVX_GPIO_ARB_ISSUE) | (w_wait & ~w_s_resp));
  assign w_in_flight[1] =  r_owner & ((r_state == RVX_GPIO_ARB_ISSUE) | (w_wait & ~w_s_resp));

  rvx_gpio_arbiter_slot u_slot0 (
    .clock            (clock),
    .reset_n          (reset_n),
    .i_rw_address     (m0_rw_address),
    .i_write_data     (m0_write_data),
    .i_write_strobe   (m0_write_strobe),
    .i_read_request   (m0_read_request),
    .i_write_request  (m0_write_request),
    .i_in_flight      (w_in_flight[0]),
    .i_grant          (w_grant[0]),
    .o_full           (w_full[0]),
    .o_rd             (w_rd[0]),
    .o_wr             (w_wr[0]),
    .o_rw_address     (w_addr[0]),
    .o_write_data     (w_wdata[0]),
    .o_write_strobe   (w_strobe[0]),
    .o_protocol_error (protocol_error[0])
  );

  rvx_gpio_arbiter_slot u_slot1 (
    .clock            (clock),
    .reset_n          (reset_n),
    .i_rw_address     (m1_rw_address),
    .i_write_data     (m1_write_data),
    .i_write_strobe   (m1_write_strobe),
    .i_read_request   (m1_read_request),
    .i_write_request  (m1_write_request),
    .i_in_flight      (w_in_flight[1]),
    .i_grant          (w_grant[1]),
    .o_full           (w_full[1]),
    .o_rd             (w_rd[1]),
    .o_wr             (w_wr[1]),
    .o_rw_address     (w_addr[1]),
    .o_write_data     (w_wdata[1]),
    .o_write_strobe   (w_strobe[1]),
    .o_protocol_error (protocol_error[1])
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RVX_GPIO_ARB_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_s_strobe   <= '0;
      r_s_rd_req   <= 1'b0;
      r_s_wr_req   <= 1'b0;
    end else begin
      case (r_state)
        RVX_GPIO_ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_s_addr     <= w_addr[w_grant_idx];
            r_s_wdata    <= w_wdata[w_grant_idx];
            r_s_strobe   <= w_strobe[w_grant_idx];
            r_s_rd_req   <= w_rd[w_grant_idx];
            r_s_wr_req   <= w_wr[w_grant_idx];
            r_state      <= RVX_GPIO_ARB_ISSUE;
          end
        end
        RVX_GPIO_ARB_ISSUE: begin
          r_s_rd_req <= 1'b0;
          r_s_wr_req <= 1'b0;
          r_state    <= RVX_GPIO_ARB_WAIT;
        end
        RVX_GPIO_ARB_WAIT: begin
          if (w_s_resp) begin
            r_state <= RVX_GPIO_ARB_IDLE;
          end
        end
        default: begin
          r_state <= RVX_GPIO_ARB_IDLE;
        end
      endcase
    end
  end

  assign s_rw_address    = r_s_addr;
  assign s_write_data    = r_s_wdata;
  assign s_write_strobe  = r_s_strobe;
  assign s_read_request  = r_s_rd_req;
  assign s_write_request = r_s_wr_req;

  assign m0_read_response  = s_read_response  & ~r_owner & w_wait;
  assign m0_write_response = s_write_response & ~r_owner & w_wait;
  assign m1_read_response  = s_read_response  &  r_owner & w_wait;
  assign m1_write_response = s_write_response &  r_owner & w_wait;
  assign m0_read_data      = m0_read_response ? s_read_data : 32'h0;
  assign m1_read_data      = m1_read_response ? s_read_data : 32'h0;

endmodule

`default_nettype wire
